// File: rtl/memory_unit_pkg.sv
// memory_unit_pkg: shared opcode constants, decode helpers and FSM state type for the memory stage.
package memory_unit_pkg;
   localparam logic [6:0] OP_NOP     = 7'b0100000;
   localparam logic [6:0] MEM_MASK_A = 7'b1100000;
   localparam logic [6:0] MEM_VAL_A  = 7'b1100000;
   localparam logic [6:0] MEM_MASK_B = 7'b1111000;
   localparam logic [6:0] MEM_VAL_B  = 7'b1000000;
   localparam logic [7:0] WAIT_LIMIT = 8'd255;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
   function automatic logic is_class_a(input logic [6:0] op);
      return (op & MEM_MASK_A) == MEM_VAL_A;
   endfunction
   function automatic logic is_lit(input logic [6:0] op);
      return (op & MEM_MASK_B) == MEM_VAL_B;
   endfunction
   function automatic logic is_mem(input logic [6:0] op);
      return is_class_a(op) || is_lit(op);
   endfunction
   function automatic logic is_load(input logic [6:0] op);
      return is_class_a(op) ? op[4] : is_lit(op);
   endfunction
   function automatic logic is_wb(input logic [6:0] op);
      return is_class_a(op) && op[2];
   endfunction
endpackage

// File: rtl/memory_pipeline_unit.sv
// memory_pipeline_unit: stage register with capture enable and flush-to-NOP.
module memory_pipeline_unit
   import memory_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [6:0]  i_opcode,
   input  logic [31:0] i_alu,
   input  logic [31:0] i_sd,
   output logic [31:0] o_instr,
   output logic [6:0]  o_opcode,
   output logic [31:0] o_alu,
   output logic [31:0] o_sd
);
   logic [31:0] r_instr, r_alu, r_sd;
   logic [6:0]  r_opcode;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr  <= '0;
         r_opcode <= OP_NOP;
         r_alu    <= '0;
         r_sd     <= '0;
      end else if (i_en) begin
         r_instr  <= i_flush ? '0 : i_instr;
         r_opcode <= i_flush ? OP_NOP : i_opcode;
         r_alu    <= i_alu;
         r_sd     <= i_sd;
      end
   end
   assign o_instr  = r_instr;
   assign o_opcode = r_opcode;
   assign o_alu    = r_alu;
   assign o_sd     = r_sd;
endmodule

// File: rtl/memory_unit.sv
// memory_unit: memory pipeline stage issuing one load/store request per captured memory op.
module memory_unit
   import memory_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_in,
   input  logic [6:0]  opcode_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic        branch_in,
   input  logic        sel_stall,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [6:0]  opcode_memory,
   output logic [3:0]  rn_memory,
   output logic [3:0]  rd_memory,
   output logic [1:0]  sel_w_addr1_memory,
   output logic [31:0] wb_data,
   output logic [31:0] instr_output,
   output logic        stall_mem,
   output logic        mem_timeout
);
   logic [31:0] w_instr, w_alu, w_sd;
   logic [6:0]  w_op, w_op_in;
   logic        w_capture, w_enter;
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_wait, w_wait_nxt;
   logic        r_timeout;
   logic [31:0] r_ld_data;
   memory_pipeline_unit u_pipe (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_capture),
      .i_flush  (branch_in),
      .i_instr  (instr_in),
      .i_opcode (opcode_in),
      .i_alu    (alu_result_in),
      .i_sd     (store_data_in),
      .o_instr  (w_instr),
      .o_opcode (w_op),
      .o_alu    (w_alu),
      .o_sd     (w_sd)
   );
   assign w_op_in   = branch_in ? OP_NOP : opcode_in;
   assign w_capture = !sel_stall && !stall_mem;
   assign w_enter   = w_capture && is_mem(w_op_in);
   always_comb begin
      w_state_nxt = w_capture ? (w_enter ? S_REQ : S_IDLE)
                  : (r_state == S_REQ && mem_ready) ? S_DONE : r_state;
      w_wait_nxt  = w_enter ? 8'd0
                  : (r_state == S_REQ && !mem_ready && r_wait != WAIT_LIMIT) ? r_wait + 8'd1 : r_wait;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_timeout <= 1'b0;
         r_ld_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wait    <= w_wait_nxt;
         r_timeout <= r_timeout || (w_wait_nxt == WAIT_LIMIT);
         if (r_state == S_REQ && mem_ready && is_load(w_op)) r_ld_data <= mem_rdata;
      end
   end
   assign mem_req            = r_state == S_REQ;
   assign stall_mem          = r_state == S_REQ && !mem_ready;
   assign mem_we             = !is_load(w_op);
   assign mem_addr           = w_alu;
   assign mem_wdata          = w_sd;
   assign opcode_memory      = w_op;
   assign rn_memory          = w_instr[19:16];
   assign rd_memory          = w_instr[15:12];
   assign sel_w_addr1_memory = is_wb(w_op) ? 2'b10 : 2'b00;
   assign wb_data            = is_load(w_op) ? r_ld_data : w_alu;
   assign instr_output       = w_instr;
   assign mem_timeout        = r_timeout;
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed and random stimulus checked against a behavioural model of the memory stage.
module tb_memory_unit;
   localparam logic [6:0] NOP = 7'b0100000, ALU = 7'b0011000, LDA = 7'b1110000;
   localparam logic [6:0] STW = 7'b1100100, LIT = 7'b1000000;
   logic clk = 1'b0, rst = 1'b1, branch_in = 1'b0, sel_stall = 1'b1, mem_ready = 1'b0;
   logic [31:0] instr_in = '0, alu_result_in = '0, store_data_in = '0, mem_rdata = '0;
   logic [6:0] opcode_in = 7'b0011000;
   logic mem_req, mem_we, stall_mem, mem_timeout;
   logic [31:0] mem_addr, mem_wdata, wb_data, instr_output;
   logic [6:0] opcode_memory;
   logic [3:0] rn_memory, rd_memory;
   logic [1:0] sel_w_addr1_memory;
   int errors = 0, checks = 0, comp = 0;
   bit go = 0;
   logic m_pend;
   logic [6:0] m_op;
   logic [31:0] m_instr, m_alu, m_sd, m_ld;
   int m_wait;
   logic m_to;
   logic [6:0] ops [4] = '{ALU, LDA, STW, LIT};

   memory_unit dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .opcode_in(opcode_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .branch_in(branch_in), .sel_stall(sel_stall), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .opcode_memory(opcode_memory),
      .rn_memory(rn_memory), .rd_memory(rd_memory),
      .sel_w_addr1_memory(sel_w_addr1_memory), .wb_data(wb_data),
      .instr_output(instr_output), .stall_mem(stall_mem), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   function automatic bit mdl_mem(input logic [6:0] op);
      return op[6:5] == 2'b11 || op[6:3] == 4'b1000;
   endfunction
   function automatic bit mdl_load(input logic [6:0] op);
      return (op[6:5] == 2'b11 && op[4]) || op[6:3] == 4'b1000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      bit stall, cap;
      logic [6:0] eop;
      stall = m_pend && !mem_ready;
      cap = !sel_stall && !stall;
      eop = branch_in ? NOP : opcode_in;
      if (rst) begin
         m_pend = 0; m_op = NOP; m_instr = 0; m_alu = 0; m_sd = 0; m_ld = 0; m_wait = 0; m_to = 0;
      end else begin
         if (m_pend && mem_ready && mdl_load(m_op)) m_ld = mem_rdata;
         if (m_pend && !mem_ready && m_wait < 255) m_wait++;
         if (m_wait == 255) m_to = 1;
         if (cap) begin
            if (mdl_mem(eop)) m_wait = 0;
            m_pend = mdl_mem(eop);
            m_op = eop;
            m_instr = branch_in ? 32'h0 : instr_in;
            m_alu = alu_result_in;
            m_sd = store_data_in;
         end else if (m_pend && mem_ready) m_pend = 0;
      end
      if (mem_req && mem_ready && !rst) comp++;
   end

   always @(negedge clk) begin
      #1;
      if (go) begin
         chk("mem_req", mem_req, m_pend);
         chk("stall_mem", stall_mem, m_pend && !mem_ready);
         chk("opcode_memory", opcode_memory, m_op);
         chk("rn_memory", rn_memory, m_instr[19:16]);
         chk("rd_memory", rd_memory, m_instr[15:12]);
         chk("instr_output", instr_output, m_instr);
         chk("sel_w", sel_w_addr1_memory, (m_op[6:5] == 2'b11 && m_op[2]) ? 2'b10 : 2'b00);
         chk("wb_data", wb_data, mdl_load(m_op) ? m_ld : m_alu);
         chk("mem_timeout", mem_timeout, m_to);
         if (m_pend) begin
            chk("mem_we", mem_we, !mdl_load(m_op));
            chk("mem_addr", mem_addr, m_alu);
            chk("mem_wdata", mem_wdata, m_sd);
         end
      end
   end

   initial begin
      tick(); rst = 1;
      tick(); rst = 0; go = 1;
      #2 chk("reset_req", mem_req, 0); chk("reset_op", opcode_memory, NOP);
      chk("reset_stall", stall_mem, 0); chk("reset_to", mem_timeout, 0);
      // ALU op passes through without a request
      opcode_in = ALU; instr_in = 32'h0000_3000; alu_result_in = 32'h1234; sel_stall = 0;
      tick(); sel_stall = 1;
      #2 chk("alu_req", mem_req, 0); chk("alu_rd", rd_memory, 3);
      chk("alu_wb", wb_data, 32'h1234); chk("alu_stall", stall_mem, 0);
      // single-cycle load
      tick(); sel_stall = 0; opcode_in = LDA; alu_result_in = 32'h100; mem_ready = 1;
      mem_rdata = 32'hDEADBEEF; instr_in = 32'h0001_2000;
      tick(); sel_stall = 1;
      #2 chk("ld_req", mem_req, 1); chk("ld_we", mem_we, 0);
      chk("ld_addr", mem_addr, 32'h100); chk("ld_stall", stall_mem, 0);
      tick();
      #2 chk("ld_req_drop", mem_req, 0); chk("ld_wb", wb_data, 32'hDEADBEEF);
      chk("model_ld", m_ld, 32'hDEADBEEF);
      // store waiting three cycles
      tick(); sel_stall = 0; opcode_in = STW; alu_result_in = 32'h200;
      store_data_in = 32'hCAFEF00D; mem_ready = 0; comp = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         #2 chk("st_stall", stall_mem, 1); chk("st_we", mem_we, 1);
         chk("st_wdata", mem_wdata, 32'hCAFEF00D);
      end
      tick(); mem_ready = 1; sel_stall = 1;
      #2 chk("st_stall_end", stall_mem, 0); chk("st_selw", sel_w_addr1_memory, 2'b10);
      tick();
      #2 chk("st_req_drop", mem_req, 0);
      tick();
      #2 chk("st_completions", comp, 1);
      // literal load completing under a downstream stall
      tick(); sel_stall = 0; opcode_in = LIT; alu_result_in = 32'h300; mem_rdata = 32'h55AA55AA; comp = 0;
      tick(); sel_stall = 1;
      #2 chk("lit_req", mem_req, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         #2 chk("lit_hold_req", mem_req, 0); chk("lit_wb", wb_data, 32'h55AA55AA);
      end
      chk("lit_completions", comp, 1);
      // wait-counter timeout
      tick(); sel_stall = 0; opcode_in = LDA; alu_result_in = 32'h400; mem_ready = 0;
      tick(); sel_stall = 1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         #2 chk("to_flag", mem_timeout, i >= 255); chk("to_req", mem_req, 1);
      end
      chk("model_to", m_to, 1);
      tick(); rst = 1;
      tick(); rst = 0;
      #2 chk("to_clear", mem_timeout, 0); chk("to_req_clear", mem_req, 0);
      // flush on capture
      sel_stall = 0; branch_in = 1; opcode_in = LDA; instr_in = 32'hFFFF_FFFF;
      tick(); branch_in = 0; sel_stall = 1;
      #2 chk("br_op", opcode_memory, NOP); chk("br_selw", sel_w_addr1_memory, 2'b00);
      chk("br_req", mem_req, 0); chk("br_instr", instr_output, 0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom % 64) == 0;
         branch_in = ($urandom % 8) == 0;
         sel_stall = ($urandom % 4) == 0;
         mem_ready = ($urandom % 2) == 0;
         opcode_in = ($urandom % 5 == 4) ? 7'($urandom) : ops[$urandom % 4];
         instr_in = $urandom; alu_result_in = $urandom;
         store_data_in = $urandom; mem_rdata = $urandom;
      end
      tick(); rst = 0;
      tick();
      #2 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-002 The block SHALL have these ports:
  clk  in  1  clock.
  rst  in  1  synchronous active-high reset.
  instr_in  in  32  instruction from execute stage.
  opcode_in  in  7  decoded opcode from execute stage.
  alu_result_in  in  32  ALU result; the memory address for memory ops.
  store_data_in  in  32  store data (Rd value).
  branch_in  in  1  flush; squash the captured instruction to NOP.
  sel_stall  in  1  downstream stall; hold stage.
  mem_rdata  in  32  data memory read data.
  mem_ready  in  1  memory completes the current request this cycle.
  mem_req  out  1  memory request valid.
  mem_we  out  1  1 = store, 0 = load; valid with mem_req.
  mem_addr  out  32  request address.
  mem_wdata  out  32  store data.
  opcode_memory  out  7  held opcode, forwarded to execute.
  rn_memory  out  4  held instr[19:16].
  rd_memory  out  4  held instr[15:12].
  sel_w_addr1_memory  out  2  2'b10 when the held op writes back Rn, else 2'b00.
  wb_data  out  32  load data for loads, ALU result otherwise.
  instr_output  out  32  held instruction.
  stall_mem  out  1  stage busy; upstream holds.
  mem_timeout  out  1  sticky wait-overflow flag.

Function
REQ-003 Memory op SHALL be opcode[6:5]==2'b11 (load iff opcode[4]=1; Rn writeback iff opcode[2]=1) or opcode[6:3]==4'b1000 (LDR_Lit, always load, no writeback).
REQ-004 The stage register SHALL capture all *_in on a rising edge iff rst=0, sel_stall=0 and stall_mem=0; otherwise it holds.
REQ-005 A capture with branch_in=1 SHALL load opcode NOP (7'b0100000) and instr 0 in place of the inputs.
REQ-006 The FSM SHALL have states IDLE (no request), REQ (request outstanding) and DONE (completed, held by sel_stall).
REQ-007 Capturing a memory op SHALL move to REQ; capturing any other op SHALL move to IDLE.
REQ-008 In REQ, mem_req SHALL be 1, with mem_addr = held ALU result, mem_wdata = held store data and mem_we = not load.
REQ-009 mem_req SHALL be 0 in IDLE and DONE; no request is ever reissued for the same instruction.
REQ-010 On an edge in REQ with mem_ready=1, load data SHALL register mem_rdata (loads only).
REQ-011 On that edge, the next state SHALL be the next captured op's state if capture occurs, else DONE.
REQ-012 stall_mem SHALL equal (state==REQ && !mem_ready), combinationally; single-cycle completion adds zero stall.
REQ-013 sel_stall=1 in REQ SHALL NOT block completion; it only blocks capture.
REQ-014 Minimum memory latency SHALL be one cycle: request in the cycle after capture, data on wb_data the cycle after mem_ready.
REQ-015 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle with mem_ready=0, saturating at 255.
REQ-016 The counter reaching 255 SHALL set mem_timeout, which stays set until reset; the request continues.
REQ-017 Forwarding outputs SHALL be driven from held registers only (no combinational path from *_in).
REQ-018 sel_w_addr1_memory SHALL be 2'b10 only for a held memory op with opcode[6:5]==2'b11 and opcode[2]=1.

Reset
REQ-019 On a rst=1 edge, the block SHALL set state IDLE, opcode_memory=NOP, all other registers 0 and mem_timeout 0; mem_req and stall_mem are then 0.
REQ-020 Reset during REQ SHALL abandon the request; mem_req SHALL be 0 from the cycle after the reset edge.

Structure
REQ-021 A shared package SHALL hold the opcode NOP constant, the FSM state enum, memory-class decode masks and the timeout limit (255).
REQ-022 The stage register SHALL be a sub-module, memory_pipeline_unit (capture, hold, flush); the FSM, counter and muxes stay in memory_unit.

Verification
REQ-023 ALU op (opcode 7'b0011000, rd=3) captured: mem_req stays 0, rd_memory=3, wb_data equals ALU result, and stall_mem=0.
REQ-024 Load from addr 0x100 with mem_ready tied 1: mem_req is high for 1 cycle with mem_we=0, and wb_data=mem_rdata (0xDEADBEEF) the next cycle.
REQ-025 Store with mem_ready held low for 3 cycles: stall_mem=1 for 3 cycles, mem_we=1, mem_wdata stable, and exactly one completion.
REQ-026 Load completes while sel_stall=1 for 4 cycles: the FSM goes REQ->DONE, mem_req=0 during the hold, and no second request occurs.
REQ-027 mem_ready held 0 for 300 cycles: mem_timeout rises after 255 wait cycles and stays high; rst=1 then clears it along with mem_req.
REQ-028 Capture with branch_in=1: opcode_memory=NOP, sel_w_addr1_memory=2'b00 and mem_req=0; a writeback store (opcode[2]=1) gives sel_w_addr1_memory=2'b10.
